// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the door-lock keypad front end (package sys_door_pkg).
// Holds the conditioner FSM encoding, the button count and the default debounce length.
package sys_door_pkg;

    localparam int unsigned NBTN                = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REJECT = 2'd2
    } state_e;

    function automatic logic [2:0] count_ones(input logic [NBTN:1] v);
        logic [2:0] n;
        n = '0;
        for (int i = 1; i <= int'(NBTN); i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Keypad-side bundle of the button conditioner: raw buttons in, conditioned events out.
// press_cnt exists only when BTN_PRESS_CNT_EN is defined.
interface button_conditioner_if;
    import sys_door_pkg::*;

    logic [NBTN:1] btn_raw;
    logic [NBTN:1] btn;
    logic          multi_err;
    logic          busy;
`ifdef BTN_PRESS_CNT_EN
    logic [7:0]    press_cnt;

    modport master (output btn_raw, input btn, multi_err, busy, press_cnt);
    modport slave  (input btn_raw, output btn, multi_err, busy, press_cnt);
`else
    modport master (output btn_raw, input btn, multi_err, busy);
    modport slave  (input btn_raw, output btn, multi_err, busy);
`endif

endinterface

// File: rtl/button_conditioner_btn_debounce.sv
// One button bit: SYNC_STAGES-flop synchronizer followed by a stability counter that only
// commits a level change after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rs,
    input  logic raw,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;

    assign sync = sync_q[SYNC_STAGES-1];
    assign deb  = deb_q;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    // Any sample agreeing with the committed level restarts the count, so bounces never pass.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Keypad conditioner: debounces four raw buttons and emits one single-cycle one-hot pulse per
// clean press, rejecting overlapping presses. BTN_PRESS_CNT_EN adds a saturating press counter.
module button_conditioner
    import sys_door_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 8
) (
    input logic                 clk,
    input logic                 rs,
    button_conditioner_if.slave bus
);

    logic [NBTN:1] deb, deb_q, rise;
    logic [NBTN:1] btn_q, btn_d;
    logic          err_q, err_d;
    logic          busy_q;
    state_e        state_q, state_d;

    for (genvar i = 1; i <= int'(NBTN); i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk(clk),
            .rs (rs),
            .raw(bus.btn_raw[i]),
            .deb(deb[i])
        );
    end

    assign rise = deb & ~deb_q;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q <= IDLE;
            deb_q   <= '0;
            btn_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb;
            btn_q   <= btn_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Leaving HELD/REJECT needs every debounced level low, so one physical press = one event.
    always_comb begin
        state_d = state_q;
        btn_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_ones(rise) == 3'd1 && (deb & ~rise) == '0) begin
                    btn_d   = rise;
                    state_d = HELD;
                end else if (count_ones(rise) >= 3'd2) begin
                    err_d   = 1'b1;
                    state_d = REJECT;
                end
            end
            HELD: begin
                if (rise != '0) begin
                    err_d   = 1'b1;
                    state_d = REJECT;
                end else if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            REJECT: begin
                if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.btn       = btn_q;
    assign bus.multi_err = err_q;
    assign bus.busy      = busy_q;

`ifdef BTN_PRESS_CNT_EN
    logic [7:0] press_cnt_q;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            press_cnt_q <= '0;
        end else if (btn_q != '0 && press_cnt_q != 8'hff) begin
            press_cnt_q <= press_cnt_q + 8'd1;
        end
    end

    assign bus.press_cnt = press_cnt_q;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: scenario tasks compared cycle by cycle against a behavioural
// model built from sample-window debouncing and a lock/reject press policy.
module tb_button_conditioner;
    import sys_door_pkg::*;

    localparam int unsigned S    = 2;
    localparam int unsigned D    = 4;
    localparam int unsigned HLEN = S + D;

    logic clk = 1'b0;
    logic rs;

    button_conditioner_if bus_if ();

    button_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .clk(clk),
        .rs (rs),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a level commits once the last D synchronized samples all disagree with it.
    logic [4:1] hist [HLEN];
    logic [4:1] m_deb = '0, m_deb_q = '0, m_btn = '0;
    logic       m_err = 1'b0, m_locked = 1'b0, m_rejected = 1'b0;
    int         m_cnt = 0;

    initial begin
        logic [4:1] rise, nd;
        logic       all_diff;
        for (int i = 0; i < int'(HLEN); i++) hist[i] = '0;
        forever begin
            @(posedge clk or negedge rs);
            if (!rs) begin
                for (int i = 0; i < int'(HLEN); i++) hist[i] = '0;
                m_deb = '0; m_deb_q = '0; m_btn = '0;
                m_err = 1'b0; m_locked = 1'b0; m_rejected = 1'b0; m_cnt = 0;
            end else begin
                rise = m_deb & ~m_deb_q;
                if (m_btn != '0 && m_cnt < 255) m_cnt++;
                m_btn = '0;
                m_err = 1'b0;
                if (!m_locked) begin
                    if ($countones(rise) == 1 && (m_deb & ~rise) == '0) begin
                        m_btn = rise; m_locked = 1'b1;
                    end else if ($countones(rise) > 1) begin
                        m_err = 1'b1; m_locked = 1'b1; m_rejected = 1'b1;
                    end
                end else if (rise != '0) begin
                    if (!m_rejected) begin
                        m_err = 1'b1; m_rejected = 1'b1;
                    end
                end else if (m_deb == '0) begin
                    m_locked = 1'b0; m_rejected = 1'b0;
                end
                for (int i = int'(HLEN) - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = bus_if.btn_raw;
                nd = m_deb;
                for (int b = 1; b <= 4; b++) begin
                    all_diff = 1'b1;
                    for (int j = int'(S); j < int'(HLEN); j++)
                        if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = ~m_deb[b];
                end
                m_deb_q = m_deb;
                m_deb   = nd;
            end
        end
    end

    function automatic logic [13:0] obs();
        logic [7:0] pc;
`ifdef BTN_PRESS_CNT_EN
        pc = bus_if.press_cnt;
`else
        pc = 8'd0;
`endif
        return {bus_if.btn, bus_if.multi_err, bus_if.busy, pc};
    endfunction

    function automatic logic [13:0] expv();
        logic [7:0] pc;
`ifdef BTN_PRESS_CNT_EN
        pc = 8'(m_cnt);
`else
        pc = 8'd0;
`endif
        return {m_btn, m_err, m_locked, pc};
    endfunction

    task automatic test_reset();
        rs = 1'b0;
        bus_if.btn_raw = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== 14'd0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h want 0", k, obs());
            end
        end
        bus_if.btn_raw = '0;
        rs = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int pulses = 0, first = -1, last_busy = -1;
        for (int k = 1; k <= 24; k++) begin
            bus_if.btn_raw = (k <= 10) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL clean_press cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (bus_if.btn != '0) begin pulses++; if (first < 0) first = k; end
            if (bus_if.busy) last_busy = k;
        end
        vectors++;
        if (pulses != 1 || first != 7 || last_busy != 16) begin
            miscompares++;
            $display("FAIL clean_press_timing: got pulses=%0d edge=%0d busy_end=%0d want 1/7/16",
                     pulses, first, last_busy);
        end
    endtask

    task automatic test_bounce();
        logic [4:1] stim[$];
        logic [4:1] key;
        int segs, stable_at, pulses = 0, first = -1;
        key  = 4'b0001 << $urandom_range(0, 3);
        segs = 2 + int'($urandom_range(0, 4));
        for (int s = 0; s < segs; s++) begin
            repeat ($urandom_range(1, D - 1)) stim.push_back(key);
            repeat ($urandom_range(1, D - 1)) stim.push_back(4'b0000);
        end
        stable_at = stim.size() + 1;
        repeat (12) stim.push_back(key);
        repeat (14) stim.push_back(4'b0000);
        for (int k = 1; k <= stim.size(); k++) begin
            bus_if.btn_raw = stim[k-1];
            @(negedge clk);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (bus_if.btn != '0) begin pulses++; if (first < 0) first = k - stable_at + 1; end
        end
        vectors++;
        if (pulses != 1 || first != 7) begin
            miscompares++;
            $display("FAIL bounce_pulse: got pulses=%0d edge=%0d want 1/7", pulses, first);
        end
    endtask

    task automatic test_password();
        logic [4:1] keys [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
        logic [15:0] seq = '0;
        int n = 0, k = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 20; c++) begin
                bus_if.btn_raw = (c < 10) ? keys[p] : 4'b0000;
                @(negedge clk);
                k++;
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL password cyc %0d: got %h want %h", k, obs(), expv());
                end
                if (bus_if.btn != '0) begin n++; seq = {seq[11:0], bus_if.btn}; end
            end
        end
        vectors++;
        if (n != 4 || seq != 16'h1428) begin
            miscompares++;
            $display("FAIL password_order: got n=%0d seq=%h want 4/1428", n, seq);
        end
    endtask

    task automatic test_overlap();
        logic [4:1] a, b, first_key = '0;
        int pulses = 0, errs = 0, busy_hi = 0;
        a = 4'b0001 << $urandom_range(0, 3);
        do b = 4'b0001 << $urandom_range(0, 3); while (b == a);
        for (int k = 1; k <= 44; k++) begin
            bus_if.btn_raw = (k <= 10) ? a : (k <= 20) ? (a | b) : (k <= 30) ? b : 4'b0000;
            @(negedge clk);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL overlap cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (bus_if.btn != '0) begin pulses++; first_key = bus_if.btn; end
            if (bus_if.multi_err) errs++;
            if (bus_if.busy) busy_hi++;
        end
        vectors++;
        if (pulses != 1 || first_key != a || errs != 1 || busy_hi != 30) begin
            miscompares++;
            $display("FAIL overlap_policy: got p=%0d key=%b err=%0d busy=%0d want 1/%b/1/30",
                     pulses, first_key, errs, busy_hi, a);
        end
    endtask

    task automatic test_reset_mid_hold();
        int pulses = 0, first = -1;
        for (int k = 1; k <= 10; k++) begin
            bus_if.btn_raw = 4'b0100;
            @(negedge clk);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL mid_hold_pre cyc %0d: got %h want %h", k, obs(), expv());
            end
        end
        rs = 1'b0;
        #1;
        vectors++;
        if (bus_if.btn !== 4'b0000 || bus_if.busy !== 1'b0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL mid_hold_clear: got %h want 0", obs());
        end
        repeat (2) @(negedge clk);
        rs = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            bus_if.btn_raw = (k <= 12) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL mid_hold_post cyc %0d: got %h want %h", k, obs(), expv());
            end
            if (bus_if.btn != '0) begin pulses++; if (first < 0) first = k; end
        end
        vectors++;
        if (pulses != 1 || first != 7) begin
            miscompares++;
            $display("FAIL mid_hold_repulse: got pulses=%0d edge=%0d want 1/7", pulses, first);
        end
    endtask

    task automatic test_random();
        logic [4:1] pat;
        int k = 0;
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 2))
                0:       pat = 4'b0000;
                1:       pat = 4'b0001 << $urandom_range(0, 3);
                default: pat = 4'($urandom_range(0, 15));
            endcase
            repeat ($urandom_range(1, 12)) begin
                bus_if.btn_raw = pat;
                @(negedge clk);
                k++;
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL random cyc %0d: got %h want %h", k, obs(), expv());
                end
            end
        end
        bus_if.btn_raw = '0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        rs = 1'b0;
        bus_if.btn_raw = 4'b0101;
        test_reset();
        test_clean_press();
        test_bounce();
        test_password();
        test_overlap();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
